lunc_arbiter: RTL and testbench

Round-robin scheduler that shares one case-transform datapath among `NUM_CH` independent byte streams. Each channel has its own escape-command mode state (Lower/Upper/None/Change). The block consumes command sequences, transforms data bytes under the owning channel's mode, and emits one tagged byte per cycle through a registered valid/ready output. It sits between the per-channel receive buffers and the shared output sink.

---
 rtl/lunc_pkg.sv | 34 +++
 rtl/lunc_xform.sv | 21 ++
 rtl/lunc_arbiter.sv | 148 ++++++++++++++
 tb/tb_lunc_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lunc_pkg.sv
// Shared constants, mode encoding and command decode helpers for the lunc
// case-transform arbiter.
package lunc_pkg;

    localparam logic [7:0] ESC   = 8'h1B;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_U = 8'h55;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_C = 8'h43;

    typedef enum logic [1:0] {
        MODE_N = 2'd0,
        MODE_L = 2'd1,
        MODE_U = 2'd2,
        MODE_C = 2'd3
    } lunc_mode_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_L) || (b == CMD_U) || (b == CMD_N) || (b == CMD_C);
    endfunction

    function automatic lunc_mode_t cmd_mode(input logic [7:0] b);
        lunc_mode_t m;
        m = MODE_N;
        case (b)
            CMD_L:   m = MODE_L;
            CMD_U:   m = MODE_U;
            CMD_C:   m = MODE_C;
            default: m = MODE_N;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lunc_xform.sv
// Combinational case transform: touches only bit 5 of the byte, so there is
// never a carry into neighbouring bits.
module lunc_xform
    import lunc_pkg::*;
(
    input  logic [7:0] byte_i,
    input  lunc_mode_t mode_i,
    output logic [7:0] byte_o
);

    always_comb begin
        byte_o = byte_i;
        unique case (mode_i)
            MODE_N: byte_o = byte_i;
            MODE_L: byte_o = byte_i | 8'h20;
            MODE_U: byte_o = byte_i & 8'hDF;
            MODE_C: byte_o = byte_i ^ 8'h20;
        endcase
    end

endmodule

// File: rtl/lunc_arbiter.sv
// Round-robin arbiter sharing one case-transform datapath among NUM_CH byte
// streams, each with its own escape-command mode state.
module lunc_arbiter
    import lunc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     in_valid,
    input  logic [NUM_CH*8-1:0]   in_data,
    output logic [NUM_CH-1:0]     in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [NUM_CH*2-1:0]   mode
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] rr_q, rr_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;

    logic            slot_free;
    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W-1:0] cand;
    logic            accept;
    logic [7:0]      gnt_byte;
    logic            gnt_esc;
    lunc_mode_t      gnt_mode;
    logic            is_esc_byte;
    logic            is_cmd_byte;
    logic            emit;
    logic [7:0]      xf_byte;

    logic [NUM_CH-1:0] esc_vec;
    lunc_mode_t        mode_vec [NUM_CH];

    assign slot_free = !out_valid_q || out_ready;

    // First requesting channel at or after rr, searched cyclically.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            cand = CH_W'((int'(rr_q) + k) % int'(NUM_CH));
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign accept   = slot_free && gnt_found;
    assign in_ready = accept ? (NUM_CH'(1) << gnt_idx) : '0;

    assign gnt_byte    = in_data[{gnt_idx, 3'b000} +: 8];
    assign gnt_esc     = esc_vec[gnt_idx];
    assign gnt_mode    = mode_vec[gnt_idx];
    assign is_esc_byte = (gnt_byte == ESC);
    assign is_cmd_byte = gnt_esc && !is_esc_byte && is_cmd(gnt_byte);
    assign emit        = accept && !is_esc_byte && !is_cmd_byte;

    lunc_xform u_xform (
        .byte_i (gnt_byte),
        .mode_i (gnt_mode),
        .byte_o (xf_byte)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic       sel;
        logic       esc_q, esc_d;
        lunc_mode_t mode_q, mode_d;

        assign sel = accept && (gnt_idx == CH_W'(i));

        always_comb begin
            esc_d  = esc_q;
            mode_d = mode_q;
            if (sel) begin
                if (is_esc_byte) begin
                    esc_d = 1'b1;
                end else begin
                    esc_d = 1'b0;
                    if (is_cmd_byte) begin
                        mode_d = cmd_mode(gnt_byte);
                    end
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                esc_q  <= 1'b0;
                mode_q <= MODE_N;
            end else begin
                esc_q  <= esc_d;
                mode_q <= mode_d;
            end
        end

        assign esc_vec[i]        = esc_q;
        assign mode_vec[i]       = mode_q;
        assign mode[2*i +: 2]    = mode_q;
    end

    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            rr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
        end
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = xf_byte;
            out_ch_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_ch_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_lunc_arbiter.sv
// Self-checking bench for lunc_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural channel/queue model.
module tb_lunc_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                clock;
    logic                reset;
    logic [NUM_CH-1:0]   in_valid;
    logic [NUM_CH*8-1:0] in_data;
    logic [NUM_CH-1:0]   in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic [CH_W-1:0]     out_ch;
    logic [NUM_CH*2-1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode [NUM_CH];
    bit m_esc  [NUM_CH];
    int m_rr;
    bit m_ov;
    int m_od;
    int m_oc;

    lunc_arbiter #(.NUM_CH(NUM_CH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .mode      (mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Case change described arithmetically: letters differ by 32 between cases.
    function automatic int xf(input int b, input int m);
        bit has32;
        has32 = (b % 64) >= 32;
        case (m)
            0:       return b;
            1:       return has32 ? b : b + 32;
            2:       return has32 ? b - 32 : b;
            default: return has32 ? b - 32 : b + 32;
        endcase
    endfunction

    function automatic int cmd_of(input int b);
        case (b)
            8'h4E:   return 0;
            8'h4C:   return 1;
            8'h55:   return 2;
            8'h43:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0;
            m_esc[i]  = 1'b0;
        end
        m_rr = 0;
        m_ov = 1'b0;
        m_od = 0;
        m_oc = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_od));
        chk({tag, ".out_ch"}, 32'(out_ch), 32'(m_oc));
        for (int i = 0; i < NUM_CH; i++) begin
            chk({tag, ".mode"}, 32'(mode[2*i +: 2]), 32'(m_mode[i]));
        end
    endtask

    // One clock cycle: drive, check grant, clock, update model, check outputs.
    task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*8-1:0] d,
                        input logic r);
        int g;
        int b;
        int c;
        bit sf;
        bit emitted;
        logic [NUM_CH-1:0] exp_rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        sf = !m_ov || r;
        g  = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && v[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
        end
        exp_rdy = '0;
        if (sf && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clock);
        #1;
        emitted = 1'b0;
        if (sf && g >= 0) begin
            b    = int'(d[g*8 +: 8]);
            c    = cmd_of(b);
            m_rr = (g + 1) % NUM_CH;
            if (b == 8'h1B) begin
                m_esc[g] = 1'b1;
            end else if (m_esc[g] && c >= 0) begin
                m_esc[g]  = 1'b0;
                m_mode[g] = c;
            end else begin
                m_esc[g] = 1'b0;
                m_ov     = 1'b1;
                m_od     = xf(b, m_mode[g]);
                m_oc     = g;
                emitted  = 1'b1;
            end
        end
        if (!emitted && r) m_ov = 1'b0;
        check_outputs("step");
    endtask

    task automatic send(input int ch, input logic [7:0] b);
        logic [NUM_CH-1:0]   v;
        logic [NUM_CH*8-1:0] d;
        v = NUM_CH'(1) << ch;
        d = (NUM_CH*8)'(b) << (8 * ch);
        step(v, d, 1'b1);
    endtask

    task automatic idle();
        step('0, '0, 1'b1);
    endtask

    // Asynchronous assertion mid-cycle, synchronous release on a falling edge.
    task automatic do_reset();
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        check_outputs("rst");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 7))
            0, 1:    return 8'h1B;
            2:       return 8'h4C;
            3:       return 8'h55;
            4:       return 8'h4E;
            5:       return 8'h43;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [NUM_CH-1:0]   rv;
        logic [NUM_CH*8-1:0] rd;
        int prev_ch;

        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        #22;
        chk("init.in_ready", 32'(in_ready), 32'h0);
        check_outputs("init");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        send(0, 8'h61);
        chk("t1.data", 32'(out_data), 32'h61);
        chk("t1.ch", 32'(out_ch), 32'h0);
        idle();

        send(1, 8'h1B);
        send(1, 8'h55);
        chk("t2.modeU", 32'(mode[3:2]), 32'h2);
        send(1, 8'h61);
        chk("t2.data0", 32'(out_data), 32'h41);
        send(1, 8'h41);
        chk("t2.data1", 32'(out_data), 32'h41);
        send(1, 8'h1B);
        send(1, 8'h43);
        send(1, 8'h41);
        chk("t2.dataC", 32'(out_data), 32'h61);
        chk("t2.ch", 32'(out_ch), 32'h1);

        // All channels request every cycle: grants rotate one per cycle.
        step('1, 32'h34333231, 1'b1);
        prev_ch = int'(out_ch);
        for (int n = 0; n < 8; n++) begin
            step('1, 32'h34333231, 1'b1);
            chk("rr.order", 32'(out_ch), 32'((prev_ch + 1) % NUM_CH));
            prev_ch = int'(out_ch);
        end

        // Stall with a byte held, then release.
        for (int n = 0; n < 3; n++) step('1, 32'h44434241, 1'b0);
        step('1, 32'h44434241, 1'b1);
        step('0, '0, 1'b1);
        idle();

        send(2, 8'h1B);
        send(2, 8'h1B);
        send(2, 8'h58);
        chk("t5.data", 32'(out_data), 32'h58);
        chk("t5.mode", 32'(mode[5:4]), 32'h0);
        send(2, 8'h1B);
        send(2, 8'h4C);
        chk("t5.modeL", 32'(mode[5:4]), 32'h1);
        do_reset();
        chk("t5.rst_mode", 32'(mode[5:4]), 32'h0);

        send(3, 8'h1B);
        send(3, 8'h4C);
        send(3, 8'hFF);
        chk("t6.L_ff", 32'(out_data), 32'hFF);
        send(3, 8'h1B);
        send(3, 8'h55);
        send(3, 8'h00);
        chk("t6.U_00", 32'(out_data), 32'h00);
        chk("t6.valid", 32'(out_valid), 32'h1);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rv[i]        = ($urandom_range(0, 1) == 1);
                rd[i*8 +: 8] = rand_byte();
            end
            step(rv, rd, $urandom_range(0, 3) != 0);
            if (n == 750) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
